// File: rtl/xoodoo_pkg.sv
// Shared definitions for the Xoodoo permutation engine: widths, round constants,
// FSM encoding and bit-manipulation helpers.
package xoodoo_pkg;

    localparam int STATE_W    = 384;
    localparam int LANE_W     = 32;
    localparam int MAX_ROUNDS = 12;

    localparam logic [LANE_W-1:0] RC [0:MAX_ROUNDS-1] = '{
        32'h0000_0058, 32'h0000_0038, 32'h0000_03C0, 32'h0000_00D0,
        32'h0000_0120, 32'h0000_0014, 32'h0000_0060, 32'h0000_002C,
        32'h0000_0380, 32'h0000_00F0, 32'h0000_01A0, 32'h0000_0012
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Bit i of the result is bit STATE_W-1-i of the argument.
    function automatic logic [STATE_W-1:0] reverse_bits(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] r;
        for (int i = 0; i < STATE_W; i++) begin
            r[i] = s[STATE_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int unsigned amt);
        return (v << amt) | (v >> (LANE_W - amt));
    endfunction

endpackage

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round (theta, rho-west, iota, chi, rho-east);
// passes the state through untouched when en is low.
module xoodoo_round
    import xoodoo_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [3:0]         rc_idx,
    input  logic               en,
    output logic [STATE_W-1:0] state_out
);

    logic [LANE_W-1:0] a [0:2][0:3];
    logic [LANE_W-1:0] p [0:3];
    logic [LANE_W-1:0] e [0:3];
    logic [LANE_W-1:0] w [0:2][0:3];
    logic [LANE_W-1:0] c [0:2][0:3];
    logic [LANE_W-1:0] d [0:2][0:3];
    logic [LANE_W-1:0] rc;
    logic [STATE_W-1:0] rounded;

    always_comb begin
        rc = (rc_idx < 4'd12) ? RC[rc_idx] : '0;
    end

    // Lane (x, y) lives in word 4y+x of the flat state.
    always_comb begin
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                a[y][x] = state_in[LANE_W*(4*y+x) +: LANE_W];
            end
        end
    end

    always_comb begin
        for (int x = 0; x < 4; x++) begin
            p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        end
        for (int x = 0; x < 4; x++) begin
            e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        end
    end

    // Theta mixing, rho-west shuffle and the iota constant injection.
    always_comb begin
        for (int x = 0; x < 4; x++) begin
            w[0][x] = a[0][x] ^ e[x];
            w[1][x] = a[1][(x+3)%4] ^ e[(x+3)%4];
            w[2][x] = rotl(a[2][x] ^ e[x], 11);
        end
        w[0][0] = w[0][0] ^ rc;
    end

    always_comb begin
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                c[y][x] = w[y][x] ^ (~w[(y+1)%3][x] & w[(y+2)%3][x]);
            end
        end
    end

    always_comb begin
        for (int x = 0; x < 4; x++) begin
            d[0][x] = c[0][x];
            d[1][x] = rotl(c[1][x], 1);
            d[2][x] = rotl(c[2][(x+2)%4], 8);
        end
    end

    always_comb begin
        rounded = '0;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                rounded[LANE_W*(4*y+x) +: LANE_W] = d[y][x];
            end
        end
        state_out = en ? rounded : state_in;
    end

endmodule

// File: rtl/xoodoo_perm_core.sv
// Iterative Xoodoo[n] engine: UNROLL chained rounds per clock, run-time round
// count and selectable bit order, valid/ready on both sides.
module xoodoo_perm_core
    import xoodoo_pkg::*;
#(
    parameter int UNROLL = 1
)
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [3:0]         nrounds,
    input  logic               reverse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    localparam logic [4:0] LAST_IDX = 5'(MAX_ROUNDS - 1);
    localparam logic [4:0] STEP     = 5'(UNROLL);

    fsm_state_e         state;
    fsm_state_e         state_next;
    logic [STATE_W-1:0] state_reg;
    logic               rev_flag;
    logic [4:0]         round_idx;
    logic [3:0]         n_clamped;
    logic [4:0]         start_idx;
    logic               run_last;
    logic               accept;
    logic [STATE_W-1:0] chain [0:UNROLL];

    // A request for n rounds runs the last n constants, so the index starts at 12-n.
    always_comb begin
        n_clamped = (nrounds == 4'd0 || nrounds > 4'd12) ? 4'd12 : nrounds;
        start_idx = 5'd12 - {1'b0, n_clamped};
        run_last  = (round_idx + STEP) > LAST_IDX;
        accept    = (state == IDLE) && in_valid;
    end

    assign chain[0] = state_reg;

    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        logic [4:0] stage_idx;
        assign stage_idx = round_idx + 5'(k);

        xoodoo_round u_round (
            .state_in  (chain[k]),
            .rc_idx    (stage_idx[3:0]),
            .en        (stage_idx <= LAST_IDX),
            .state_out (chain[k+1])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (run_last)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath registers only move on accept or while running; DONE holds them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= '0;
            rev_flag  <= 1'b0;
            round_idx <= '0;
        end else if (accept) begin
            state_reg <= reverse ? reverse_bits(state_in) : state_in;
            rev_flag  <= reverse;
            round_idx <= start_idx;
        end else if (state == RUN) begin
            state_reg <= chain[UNROLL];
            round_idx <= round_idx + STEP;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_out = rev_flag ? reverse_bits(state_reg) : state_reg;

endmodule

// File: tb/tb_xoodoo_perm_core.sv
// Self-checking bench: two cores (UNROLL=1 and UNROLL=4) against a word-array
// Xoodoo model, table vectors, random runs, backpressure and mid-run reset.
module tb_xoodoo_perm_core;

    localparam logic [31:0] RC_TB [12] = '{
        32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
    };

    typedef struct {
        logic [383:0] s;
        logic [3:0]   n;
        logic         rv;
        logic [383:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [383:0] state_in  [2];
    logic [3:0]   nrounds   [2];
    logic         reverse   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [383:0] state_out [2];
    logic         busy      [2];

    int error_count = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    xoodoo_perm_core #(.UNROLL(1)) dut_u1 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .state_in(state_in[0]),
        .nrounds(nrounds[0]), .reverse(reverse[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .state_out(state_out[0]),
        .busy(busy[0])
    );

    xoodoo_perm_core #(.UNROLL(4)) dut_u4 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .state_in(state_in[1]),
        .nrounds(nrounds[1]), .reverse(reverse[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .state_out(state_out[1]),
        .busy(busy[1])
    );

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [383:0] flip(input logic [383:0] s);
        logic [383:0] r;
        for (int i = 0; i < 384; i++) r[i] = s[383-i];
        return r;
    endfunction

    function automatic int clamp_n(input int n);
        return (n == 0 || n > 12) ? 12 : n;
    endfunction

    function automatic logic [383:0] rand_state();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference Xoodoo[n] on a flat array of 12 words, word 4y+x = lane (x,y).
    function automatic logic [383:0] xoodoo_model(input logic [383:0] s, input int n, input logic rv);
        logic [31:0]  w [12];
        logic [31:0]  p [4];
        logic [31:0]  t [4];
        logic [31:0]  b0, b1, b2;
        logic [383:0] src;
        logic [383:0] res;
        src = rv ? flip(s) : s;
        for (int i = 0; i < 12; i++) w[i] = src[32*i +: 32];
        for (int r = 12 - clamp_n(n); r < 12; r++) begin
            for (int x = 0; x < 4; x++) p[x] = w[x] ^ w[x+4] ^ w[x+8];
            for (int i = 0; i < 12; i++) w[i] = w[i] ^ rl(p[(i+3)%4], 5) ^ rl(p[(i+3)%4], 14);
            for (int x = 0; x < 4; x++) t[x] = w[4+x];
            for (int x = 0; x < 4; x++) w[4+x] = t[(x+3)%4];
            for (int x = 0; x < 4; x++) w[8+x] = rl(w[8+x], 11);
            w[0] = w[0] ^ RC_TB[r];
            for (int x = 0; x < 4; x++) begin
                b0 = w[x]; b1 = w[4+x]; b2 = w[8+x];
                w[x]   = b0 ^ (~b1 & b2);
                w[4+x] = b1 ^ (~b2 & b0);
                w[8+x] = b2 ^ (~b0 & b1);
            end
            for (int x = 0; x < 4; x++) w[4+x] = rl(w[4+x], 1);
            for (int x = 0; x < 4; x++) t[x] = w[8+x];
            for (int x = 0; x < 4; x++) w[8+x] = rl(t[(x+2)%4], 8);
        end
        for (int i = 0; i < 12; i++) res[32*i +: 32] = w[i];
        return rv ? flip(res) : res;
    endfunction

    function automatic vec_t make_vec(input logic [383:0] s, input logic [3:0] n, input logic rv);
        vec_t v;
        v.s = s; v.n = n; v.rv = rv;
        v.exp = xoodoo_model(s, int'(n), rv);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one state, then scramble the inputs and count cycles until out_valid.
    task automatic applyStimulus(input int u, input logic [383:0] s, input logic [3:0] n,
                                 input logic rv, output int lat);
        @(negedge clk);
        state_in[u] = s; nrounds[u] = n; reverse[u] = rv; in_valid[u] = 1'b1;
        @(negedge clk);
        in_valid[u] = 1'b0;
        state_in[u] = rand_state();
        nrounds[u]  = 4'($urandom);
        reverse[u]  = 1'($urandom);
        lat = 0;
        while (out_valid[u] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runVector(input int u, input vec_t v, input string name);
        int lat;
        int un;
        int exp_lat;
        un = (u == 0) ? 1 : 4;
        exp_lat = (clamp_n(int'(v.n)) + un - 1) / un;
        applyStimulus(u, v.s, v.n, v.rv, lat);
        checkOutput({name, " latency"}, 384'(lat), 384'(exp_lat));
        checkOutput({name, " state"}, state_out[u], v.exp);
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        checkOutput({name, " in_ready after handshake"}, 384'(in_ready[u]), 384'(1));
    endtask

    initial begin
        vec_t         vecs [8];
        vec_t         v;
        logic [383:0] sb;
        logic [383:0] held;
        int           lat;

        resetn = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; out_ready[u] = 1'b0; state_in[u] = '0;
            nrounds[u] = 4'd0; reverse[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("reset in_ready u%0d", u), 384'(in_ready[u]), 384'(1));
            checkOutput($sformatf("reset out_valid u%0d", u), 384'(out_valid[u]), 384'(0));
            checkOutput($sformatf("reset busy u%0d", u), 384'(busy[u]), 384'(0));
            checkOutput($sformatf("reset state_out u%0d", u), state_out[u], '0);
        end
        resetn = 1'b1;
        @(negedge clk);

        sb = rand_state();
        vecs[0] = make_vec('0, 4'd12, 1'b0);
        vecs[1] = make_vec(rand_state(), 4'd6, 1'b0);
        vecs[2] = make_vec(sb, 4'd12, 1'b0);
        vecs[3] = make_vec(sb, 4'd0, 1'b0);
        vecs[4] = make_vec(sb, 4'd15, 1'b0);
        vecs[5] = make_vec(rand_state(), 4'd12, 1'b1);
        vecs[6] = make_vec(384'd1, 4'd12, 1'b1);
        vecs[7] = make_vec(rand_state(), 4'd1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            for (int u = 0; u < 2; u++) begin
                runVector(u, vecs[i], $sformatf("vec%0d u%0d", i, u));
            end
        end

        for (int i = 0; i < 8; i++) begin
            v = make_vec(rand_state(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            runVector(i % 2, v, $sformatf("rand%0d n=%0d rv=%0d", i, v.n, v.rv));
        end

        // Backpressure: result must hold and in_valid pulses must be dropped.
        v = make_vec(rand_state(), 4'd3, 1'b0);
        applyStimulus(0, v.s, v.n, v.rv, lat);
        checkOutput("bp latency", 384'(lat), 384'(3));
        held = v.exp;
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("bp state c%0d", c), state_out[0], held);
            checkOutput($sformatf("bp in_ready c%0d", c), 384'(in_ready[0]), 384'(0));
            in_valid[0] = (c % 3 == 0);
            state_in[0] = rand_state();
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        checkOutput("bp state end", state_out[0], held);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        checkOutput("bp in_ready after handshake", 384'(in_ready[0]), 384'(1));
        checkOutput("bp busy after handshake", 384'(busy[0]), 384'(0));
        @(negedge clk);
        checkOutput("bp no queued accept", 384'(busy[0]), 384'(0));

        // Reset in the middle of a 12-round run on the UNROLL=1 core.
        @(negedge clk);
        state_in[0] = rand_state(); nrounds[0] = 4'd12; reverse[0] = 1'b0; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid-run busy", 384'(busy[0]), 384'(1));
        #2 resetn = 1'b0;
        #1;
        checkOutput("mid-reset in_ready", 384'(in_ready[0]), 384'(1));
        checkOutput("mid-reset out_valid", 384'(out_valid[0]), 384'(0));
        checkOutput("mid-reset busy", 384'(busy[0]), 384'(0));
        checkOutput("mid-reset state_out", state_out[0], '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        runVector(0, make_vec(rand_state(), 4'd12, 1'b1), "after reset u0");
        runVector(1, make_vec(rand_state(), 4'd7, 1'b0), "after reset u1");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
